// File: rtl/itlb_fa.sv
// Fully-associative instruction TLB between fetch and the page table walker.
// Hits translate combinationally; misses stall fetch, issue one walk and fill round-robin.
module itlb_fa #(
   parameter int VA_WIDTH    = 32,
   parameter int PPN_WIDTH   = 20,
   parameter int OFFSET_BITS = 12,
   parameter int ENTRIES     = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             F_req,
   input  logic [VA_WIDTH-1:0]              F_va,
   input  logic                             F_flush,
   output logic                             F_hit,
   output logic [PPN_WIDTH+OFFSET_BITS-1:0] F_pa,
   output logic                             F_stall,
   output logic                             Itlb_pa_request,
   output logic [VA_WIDTH-1:0]              Itlb_va,
   input  logic                             F_ptw_valid,
   input  logic [PPN_WIDTH-1:0]             F_ptw_pa,
   output logic [15:0]                      Itlb_miss_cnt
);

   localparam int VPN_W = VA_WIDTH - OFFSET_BITS;
   localparam int IDX_W = $clog2(ENTRIES);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t                 state_reg, state_next;
   logic [ENTRIES-1:0]     valid_reg;
   logic [VPN_W-1:0]       vpn_reg [ENTRIES];
   logic [PPN_WIDTH-1:0]   ppn_reg [ENTRIES];
   logic [IDX_W-1:0]       rr_ptr_reg;
   logic                   drop_reg;
   logic                   req_reg;
   logic [VA_WIDTH-1:0]    va_reg;
   logic [15:0]            miss_cnt_reg;

   logic [VPN_W-1:0]       f_vpn;
   logic [ENTRIES-1:0]     match;
   logic                   any_match;
   logic [PPN_WIDTH-1:0]   ppn_hit;
   logic                   start_walk;
   logic                   fill;

   assign f_vpn = F_va[VA_WIDTH-1:OFFSET_BITS];

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
         assign match[gi] = valid_reg[gi] && (vpn_reg[gi] == f_vpn);
      end
   endgenerate

   // At most one entry can match, so OR-ing the selected PPNs acts as a mux.
   always_comb begin
      ppn_hit = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (match[i]) ppn_hit = ppn_hit | ppn_reg[i];
      end
   end

   assign any_match  = |match;
   assign F_hit      = F_req && (state_reg == IDLE) && any_match;
   assign F_stall    = F_req && !F_hit;
   assign F_pa       = {ppn_hit, F_va[OFFSET_BITS-1:0]};
   assign start_walk = (state_reg == IDLE) && F_req && !any_match && !F_flush;
   // A flush landing on the response edge discards it just like a pending drop.
   assign fill       = (state_reg == WAIT) && F_ptw_valid && !drop_reg && !F_flush;

   assign Itlb_pa_request = req_reg;
   assign Itlb_va         = va_reg;
   assign Itlb_miss_cnt   = miss_cnt_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_walk) state_next = REQ;
         REQ:     state_next = WAIT;
         WAIT:    if (F_ptw_valid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         req_reg      <= 1'b0;
         va_reg       <= '0;
         miss_cnt_reg <= '0;
         drop_reg     <= 1'b0;
         rr_ptr_reg   <= '0;
         valid_reg    <= '0;
      end else begin
         state_reg <= state_next;
         // REQ lasts one cycle, so registering its entry yields a single-cycle pulse.
         req_reg   <= (state_next == REQ);
         if (start_walk) begin
            va_reg       <= F_va;
            miss_cnt_reg <= miss_cnt_reg + 16'd1;
         end
         if ((state_reg == WAIT) && F_ptw_valid)
            drop_reg <= 1'b0;
         else if (F_flush && (state_reg != IDLE))
            drop_reg <= 1'b1;
         if (F_flush)
            valid_reg <= '0;
         else if (fill)
            valid_reg[rr_ptr_reg] <= 1'b1;
         if (fill)
            rr_ptr_reg <= rr_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         vpn_reg[rr_ptr_reg] <= va_reg[VA_WIDTH-1:OFFSET_BITS];
         ppn_reg[rr_ptr_reg] <= F_ptw_pa;
      end
   end

endmodule
